// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage (port C) and a
// debug/loader master (port D). One access per cycle. C has priority, but after STARVE_MAX
// consecutive contested cycles won by C, D is forced a grant so it always makes progress.
//
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata        core request (held stable until c_gnt)
//   c_gnt, c_rvalid, c_rdata         core grant and read response (1 cycle after grant)
//   d_req/d_we/d_addr/d_wdata        debug request (held stable until d_gnt)
//   d_gnt, d_rvalid, d_rdata         debug grant and read response
//   core_stall                       c_req & ~c_gnt, freezes PC/pipeline registers
//   m_en/m_we/m_addr/m_wdata         memory command from the granted port (zero when idle)
//   m_rdata                          memory read data, valid 1 cycle after a read command
module dmem_arbiter #(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              core_stall,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {OwnNone, OwnC, OwnD} owner_e;

   owner_e           rd_owner_q;
   logic [CNT_W-1:0] starve_cnt_q;
   logic             contested;
   logic             d_wins;

   // Grant decode; reset gates every grant so nothing reaches memory while rst is low.
   always_comb begin
      contested  = c_req & d_req;
      d_wins     = contested & (starve_cnt_q == STARVE_LIM);
      c_gnt      = rst & c_req & ~d_wins;
      d_gnt      = rst & d_req & (~c_req | d_wins);
      core_stall = c_req & ~c_gnt;

      m_en    = c_gnt | d_gnt;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (c_gnt) begin
         m_we    = c_we;
         m_addr  = c_addr;
         m_wdata = c_wdata;
      end else if (d_gnt) begin
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end
   end

   // Read response steering: the owner register remembers who issued last cycle's read.
   always_comb begin
      c_rvalid = (rd_owner_q == OwnC);
      d_rvalid = (rd_owner_q == OwnD);
      c_rdata  = c_rvalid ? m_rdata : '0;
      d_rdata  = d_rvalid ? m_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_owner_q   <= OwnNone;
         starve_cnt_q <= '0;
      end else begin
         if (c_gnt && !c_we) begin
            rd_owner_q <= OwnC;
         end else if (d_gnt && !d_we) begin
            rd_owner_q <= OwnD;
         end else begin
            rd_owner_q <= OwnNone;
         end

         // Count only contested cycles that C won; any D grant or idle D clears it.
         if (d_gnt || !d_req) begin
            starve_cnt_q <= '0;
         end else if (contested && c_gnt && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A behavioural memory sits on the m_*
// port; a reference memory plus arbitration model predicts grants, and read responses are
// pushed to a scoreboard queue at the grant edge and popped on the response cycle.
module tb_dmem_arbiter;

   localparam int unsigned ADDR_W     = 4;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              c_req = 1'b0, c_we = 1'b0;
   logic [ADDR_W-1:0] c_addr = '0;
   logic [DATA_W-1:0] c_wdata = '0;
   logic              c_gnt, c_rvalid;
   logic [DATA_W-1:0] c_rdata;
   logic              d_req = 1'b0, d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              d_gnt, d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              core_stall, m_en, m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_gnt     (c_gnt),
      .c_rvalid  (c_rvalid),
      .c_rdata   (c_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .core_stall(core_stall),
      .m_en      (m_en),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   // Behavioural single-port memory, 1-cycle read latency.
   logic [DATA_W-1:0] mem [16];
   logic [DATA_W-1:0] mem_rdata = '0;
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr] <= m_wdata;
         else      mem_rdata   <= mem[m_addr];
      end
   end
   assign m_rdata = mem_rdata;

   typedef struct {
      logic              is_d;
      logic [DATA_W-1:0] data;
   } rsp_t;

   rsp_t              rsp_q[$];
   logic [DATA_W-1:0] ref_mem [16];
   int                starve_m = 0;
   int                n_cmp = 0;
   int                n_err = 0;
   logic              last_d_gnt, last_stall;
   logic [ADDR_W-1:0] last_m_addr;

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cwd, input logic dr, input logic dw,
                        input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd);
      c_req = cr; c_we = cw; c_addr = ca; c_wdata = cwd;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
   endtask

   // One clock cycle: inputs already driven; check at negedge, then apply rst_edge and
   // advance the reference model at the posedge.
   task automatic tick(input logic rst_edge);
      logic eg_c, eg_d, has_rsp;
      rsp_t r;
      eg_c = rst && c_req && !(d_req && starve_m == STARVE_MAX);
      eg_d = rst && d_req && !eg_c;
      @(negedge clk);
      last_d_gnt  = d_gnt;
      last_stall  = core_stall;
      last_m_addr = m_addr;
      check_eq("c_gnt", 32'(c_gnt), 32'(eg_c));
      check_eq("d_gnt", 32'(d_gnt), 32'(eg_d));
      check_eq("core_stall", 32'(core_stall), 32'(c_req && !eg_c));
      check_eq("m_en", 32'(m_en), 32'(eg_c || eg_d));
      check_eq("m_we", 32'(m_we), 32'(eg_c ? c_we : eg_d ? d_we : 1'b0));
      check_eq("m_addr", 32'(m_addr), 32'(eg_c ? c_addr : eg_d ? d_addr : '0));
      check_eq("m_wdata", m_wdata, eg_c ? c_wdata : eg_d ? d_wdata : '0);
      r = '{is_d: 1'b0, data: '0};
      has_rsp = (rsp_q.size() > 0);
      if (has_rsp) r = rsp_q.pop_front();
      check_eq("c_rvalid", 32'(c_rvalid), 32'(has_rsp && !r.is_d));
      check_eq("c_rdata", c_rdata, (has_rsp && !r.is_d) ? r.data : '0);
      check_eq("d_rvalid", 32'(d_rvalid), 32'(has_rsp && r.is_d));
      check_eq("d_rdata", d_rdata, (has_rsp && r.is_d) ? r.data : '0);
      rst = rst_edge;
      // Grants at the edge follow the rst value present at the edge.
      eg_c = rst && c_req && !(d_req && starve_m == STARVE_MAX);
      eg_d = rst && d_req && !eg_c;
      @(posedge clk);
      if (!rst_edge) begin
         starve_m = 0;
         rsp_q.delete();
      end else begin
         if (eg_c) begin
            if (c_we) ref_mem[c_addr] = c_wdata;
            else      rsp_q.push_back(rsp_t'{is_d: 1'b0, data: ref_mem[c_addr]});
         end
         if (eg_d) begin
            if (d_we) ref_mem[d_addr] = d_wdata;
            else      rsp_q.push_back(rsp_t'{is_d: 1'b1, data: ref_mem[d_addr]});
         end
         if (eg_d || !d_req)                      starve_m = 0;
         else if (eg_c && starve_m < STARVE_MAX)  starve_m++;
      end
      #1;
   endtask

   task automatic idle(input int n);
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      for (int i = 0; i < n; i++) tick(1'b1);
   endtask

   initial begin
      logic [9:0]  pat10, stall10;
      logic [4:0]  pat5;
      logic [7:0]  wide_addr;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;

      // Reset state: no grants, no responses, even with requests pending.
      @(posedge clk); #1;
      drive(1, 0, 4'h1, '0, 1, 0, 4'h2, '0);
      tick(1'b0);
      tick(1'b0);
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      tick(1'b1);

      // Preload the memory through the debug port.
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, '0, '0, 1, 1, 4'(i), (i == 3) ? 32'hDEAD_BEEF : 32'hA5A5_0000 + i);
         tick(1'b1);
      end
      idle(1);

      // Core read alone, same-cycle grant, data next cycle.
      drive(1, 0, 4'h3, '0, 0, 0, '0, '0);
      tick(1'b1);
      idle(1);

      // Held contention: C,C,C,C,D,C,C,C,C,D.
      drive(1, 0, 4'h1, '0, 1, 0, 4'h2, '0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b1);
         pat10[i]   = last_d_gnt;
         stall10[i] = last_stall;
      end
      check_eq("starve_pattern", 32'(pat10), 32'h210);
      check_eq("stall_pattern", 32'(stall10), 32'h210);
      idle(1);

      // D write, C read-back, D read-back.
      drive(0, 0, '0, '0, 1, 1, 4'h5, 32'h1234_5678);
      tick(1'b1);
      drive(1, 0, 4'h5, '0, 0, 0, '0, '0);
      tick(1'b1);
      drive(0, 0, '0, '0, 1, 0, 4'h5, '0);
      tick(1'b1);
      idle(1);

      // Build up starvation count, then reset mid-read.
      drive(1, 0, 4'h6, '0, 1, 0, 4'h7, '0);
      tick(1'b1);
      tick(1'b1);
      drive(1, 0, 4'h7, '0, 0, 0, '0, '0);
      tick(1'b0);
      drive(1, 0, 4'h7, '0, 1, 0, 4'h8, '0);
      tick(1'b0);
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      tick(1'b1);
      drive(1, 0, 4'h9, '0, 1, 0, 4'hA, '0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         pat5[i] = last_d_gnt;
      end
      check_eq("post_reset_pattern", 32'(pat5), 32'h10);
      drive(0, 0, '0, '0, 1, 0, 4'hB, '0);
      tick(1'b1);
      idle(1);

      // D alone for 8 cycles, then contention: C wins the first 4.
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, '0, '0, 1, 0, 4'(i), '0);
         tick(1'b1);
      end
      drive(1, 0, 4'hC, '0, 1, 0, 4'hD, '0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         pat5[i] = last_d_gnt;
      end
      check_eq("d_alone_then_contend", 32'(pat5), 32'h10);
      idle(1);

      // Address wrap and alternating single-owner reads.
      wide_addr = 8'h13;
      drive(1, 0, wide_addr[ADDR_W-1:0], '0, 0, 0, '0, '0);
      tick(1'b1);
      check_eq("addr_wrap", 32'(last_m_addr), 32'h3);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) drive(0, 0, '0, '0, 1, 0, 4'(i + 4), '0);
         else            drive(1, 0, 4'(i + 8), '0, 0, 0, '0, '0);
         tick(1'b1);
      end
      idle(2);
      check_eq("scoreboard_drained", 32'(rsp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
